pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor of the fixed-field inter-stage pipeline registers. One pipeline-register slot with valid/ready flow control and a 1-entry skid buffer.
- Adds back-pressure (stall), synchronous flush with bubble insertion, and control-field zeroing on bubbles. The existing data-only registers provide none of these.
- Sits between any two pipeline stages, e.g. EX->MEM. Upstream packs the datapath bus into in_data and the control bits (RegWrite, MemRead, MemWrite, ...) into in_ctrl.

Parameters:
- DATA_W, 32, payload width (aluout, read2, imm, rd ... concatenated by the instantiator).
- CTRL_W, 8, control-bit width; these bits are forced to 0 whenever the slot is a bubble.
- CLR_DATA_ON_FLUSH, 0, 1 = payload registers also cleared to 0 on flush; 0 = payload holds its value (saves power).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous flush (branch mispredict / trap); highest priority.
- in_valid, input, 1, upstream beat valid.
- in_ready, output, 1, slot can accept a beat; registered, equals !skid_valid.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream control bits.
- out_valid, output, 1, main entry valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, main entry payload.
- out_ctrl, output, CTRL_W, main entry control bits; 0 when out_valid=0.
- occupancy, output, 2, number of held beats (0, 1 or 2).

Behaviour:
- Storage:
  - main entry (main_valid, main_data, main_ctrl) drives the outputs.
  - skid entry (skid_valid, skid_data, skid_ctrl) holds a beat accepted while the downstream stalled.
- Reset (rst_n low, async): main_valid=0, skid_valid=0, all data/ctrl registers 0. Hence out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Handshakes:
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
  - in_ready does not depend combinationally on out_ready; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- Latency: one cycle, in_* to out_* when empty and not stalled. Full throughput of 1 beat/cycle when out_ready=1.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY: acc -> ONE (main <= in).
  - ONE:
    - acc & deq -> ONE (main <= in).
    - acc & !deq -> FULL (skid <= in).
    - !acc & deq -> EMPTY.
    - otherwise hold.
  - FULL (in_ready=0, so acc cannot occur): deq -> ONE (main <= skid, skid_valid <= 0); else hold.
- Ordering: beats leave in arrival order. The skid beat always moves to main before any newer beat.
- Flush (sync, overrides everything in the same cycle):
  - next cycle main_valid=0, skid_valid=0, main_ctrl=0, skid_ctrl=0.
  - data registers are cleared only if CLR_DATA_ON_FLUSH=1.
  - A beat presented with acc in the flush cycle is discarded.
  - A deq in the flush cycle still counts as consumed by downstream (its output was valid that cycle).
  - in_ready=1 the cycle after a flush.
- Bubble rule: out_ctrl = main_valid ? main_ctrl : 0, gated combinationally. Downstream may therefore use ctrl bits without qualifying by out_valid.
- occupancy = main_valid + skid_valid.
- Holding: with out_valid=1 & out_ready=0, out_data/out_ctrl stay stable until deq or flush.
- Reset mid-operation: all beats lost; state returns to EMPTY asynchronously.

Decomposition:
- Shared pipeline package:
  - localparams for the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b11).
  - control-field bit positions for the EX/MEM packing (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_RWTYPE[2:0], CTRL_LUI).
- One natural sub-module: pipe_entry. It is a single valid+data+ctrl register with load, clear and clr-data option, instantiated twice (main, skid).

Test Plan:
- Reset then idle -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
- Stream with out_ready=1: beats 0x11, 0x22, 0x33 with ctrl=0xA5 on consecutive cycles -> same values appear one cycle later, back-to-back, occupancy=1 throughout.
- Stall:
  - Send 0x11, then 0x22 while out_ready=0 -> occupancy=2 and in_ready=0.
  - 0x33 is held upstream.
  - Release out_ready -> 0x11, 0x22, 0x33 emerge in order with no loss or duplicate.
- Flush while FULL with in_valid=1 (0x44) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0x44 never appears. out_data=0 only when CLR_DATA_ON_FLUSH=1.
- Flush and deq in the same cycle in state ONE -> downstream sees the beat once, slot is EMPTY next cycle.
- Assert rst_n low asynchronously mid-stream, between clock edges, while occupancy=2 -> outputs clear immediately. After release, the first new beat has 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: slot state encoding and EX/MEM control-bit positions.
// Latency/backpressure: n/a (declarations only).
package pipe_stage_skid_pkg;

    // Slot state is {skid_valid, main_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_MEMREAD    = 1;
    localparam int CTRL_MEMWRITE   = 2;
    localparam int CTRL_MEMTOREG   = 3;
    localparam int CTRL_RWTYPE_LSB = 4;
    localparam int CTRL_RWTYPE_W   = 3;
    localparam int CTRL_LUI        = 7;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// Single valid+data+ctrl register with load, unload and clear (clear has priority).
// Latency: 1 cycle load-to-output; no backpressure of its own, driven by the slot controller.
module pipe_entry #(
    parameter int DATA_W            = 32,
    parameter int CTRL_W            = 8,
    parameter bit CLR_DATA_ON_FLUSH = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= '0;
        end else if (clr) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            // Leaving data untouched on flush avoids toggling the wide payload flops
            if (CLR_DATA_ON_FLUSH) q_data <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end else if (unload) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register slot with 1-entry skid, flush with bubble insertion, ctrl zeroed on bubbles.
// Latency 1 cycle; in_ready is registered (!skid_valid), so no out_ready->in_ready path.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W            = 32,
    parameter int CTRL_W            = 8,
    parameter bit CLR_DATA_ON_FLUSH = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic              acc, deq;
    logic              main_load, main_unload, main_from_skid;
    logic              skid_load, skid_unload;

    assign acc = in_valid & in_ready;
    assign deq = main_valid & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_unload    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        case ({skid_valid, main_valid})
            ST_EMPTY: main_load = acc;
            ST_ONE: begin
                if (deq) begin
                    main_load   = acc;
                    main_unload = !acc;
                end else begin
                    skid_load   = acc;
                end
            end
            ST_FULL: begin
                // Skid beat is older than anything upstream, so it refills main first
                if (deq) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_unload    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_entry #(
        .DATA_W            (DATA_W),
        .CTRL_W            (CTRL_W),
        .CLR_DATA_ON_FLUSH (CLR_DATA_ON_FLUSH)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .load    (main_load),
        .unload  (main_unload),
        .d_data  (main_d_data),
        .d_ctrl  (main_d_ctrl),
        .q_valid (main_valid),
        .q_data  (main_data),
        .q_ctrl  (main_ctrl)
    );

    pipe_entry #(
        .DATA_W            (DATA_W),
        .CTRL_W            (CTRL_W),
        .CLR_DATA_ON_FLUSH (CLR_DATA_ON_FLUSH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .load    (skid_load),
        .unload  (skid_unload),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
    );

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue scoreboard fed on accept, drained on dequeue.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam bit CLR_D  = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t sb_q[$];
    logic [CTRL_W-1:0] c_a5, c_5a;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W            (DATA_W),
        .CTRL_W            (CTRL_W),
        .CLR_DATA_ON_FLUSH (CLR_D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for one cycle, returning at the next rising edge + 1
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: the queue mirrors the beats held in the slot
    always @(negedge clk) begin
        if (rst_n) begin
            chk("occupancy", occupancy, sb_q.size());
            chk("in_ready", in_ready, sb_q.size() < 2);
            chk("out_valid", out_valid, sb_q.size() > 0);
            if (out_valid && sb_q.size() > 0) begin
                chk("out_data", out_data, sb_q[0].data);
                chk("out_ctrl", out_ctrl, sb_q[0].ctrl);
            end else begin
                chk("bubble_ctrl", out_ctrl, 0);
            end
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back('{data: in_data, ctrl: in_ctrl});
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        c_a5 = '0;
        c_a5[CTRL_REGWRITE] = 1'b1;
        c_a5[CTRL_MEMWRITE] = 1'b1;
        c_a5[CTRL_RWTYPE_LSB +: CTRL_RWTYPE_W] = 3'b010;
        c_a5[CTRL_LUI] = 1'b1;
        c_5a = '0;
        c_5a[CTRL_MEMREAD]  = 1'b1;
        c_5a[CTRL_MEMTOREG] = 1'b1;
        c_5a[CTRL_RWTYPE_LSB +: CTRL_RWTYPE_W] = 3'b101;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, '0, '0, 1, 0);

        // Streaming at full rate
        drive(1, 32'h11, c_a5, 1, 0);
        drive(1, 32'h22, c_a5, 1, 0);
        drive(1, 32'h33, c_a5, 1, 0);
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);

        // Stall: fill main and skid, hold 0x33 upstream, then release
        drive(1, 32'h11, c_a5, 0, 0);
        drive(1, 32'h22, c_a5, 0, 0);
        drive(1, 32'h33, c_a5, 0, 0);
        drive(1, 32'h33, c_a5, 0, 0);
        drive(1, 32'h33, c_a5, 1, 0);
        drive(1, 32'h33, c_a5, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, 0);

        // Flush while FULL with a beat offered upstream
        drive(1, 32'h55, c_5a, 0, 0);
        drive(1, 32'h66, c_5a, 0, 0);
        drive(1, 32'h44, c_5a, 0, 1);
        @(negedge clk);
        chk("flush_out_data", out_data, CLR_D ? 32'h0 : 32'h55);
        chk("flush_out_ctrl", out_ctrl, 0);
        @(posedge clk); #1;
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);

        // Flush coinciding with dequeue in ONE
        drive(1, 32'h77, c_a5, 1, 0);
        drive(0, '0, '0, 1, 1);
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);

        // Asynchronous reset between edges while FULL
        drive(1, 32'h88, c_a5, 0, 0);
        drive(1, 32'h99, c_a5, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_ctrl", out_ctrl, 0);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_in_ready", in_ready, 1);
        sb_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 32'hAB, c_5a, 1, 0);
        @(negedge clk);
        chk("post_rst_latency_vld", out_valid, 1);
        chk("post_rst_latency_dat", out_data, 32'hAB);
        @(posedge clk); #1;
        drive(0, '0, '0, 1, 0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), $urandom, CTRL_W'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < 4; i++) drive(0, '0, '0, 1, 0);
        chk("drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
